lcd_cmd_host: RTL and testbench

Command initiator for the LCD image-processing controller. Fetches a 4-bit command script from a synchronous command ROM, issues each command over the `cmd`/`cmd_valid` handshake only while the controller's `busy` is low, and stops after issuing WRITE (code 0) once the controller reports `done`. Sits on the host side of the controller's command port, in the top-level test/system wrapper.

---
 rtl/lcd_cmd_host.sv | 145 ++++++++++++++
 tb/tb_lcd_cmd_host.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_host.sv
// Host-side command initiator: walks a command ROM script and issues each code
// to the LCD controller over cmd/cmd_valid, finishing after WRITE completes.
module lcd_cmd_host #(
  parameter int unsigned CMD_DEPTH = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [3:0]                   CROM_Q,
  output logic                         CROM_rd,
  output logic [$clog2(CMD_DEPTH)-1:0] CROM_A,
  output logic [3:0]                   cmd,
  output logic                         cmd_valid,
  input  logic                         busy,
  input  logic                         done,
  output logic [6:0]                   issued_cnt,
  output logic                         finish,
  output logic                         error
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_A   = AW'(CMD_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    CODE_WRITE   = 4'd0;
  localparam logic [3:0]    CODE_ILLEGAL = 4'd12;
  localparam logic [6:0]    CNT_MAX      = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_HOLD,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   crom_a_nxt;
  logic [3:0]      cmd_nxt;
  logic [6:0]      issued_nxt;
  logic            error_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;

  // The strobe must react to busy within the ISSUE cycle itself, so it is a
  // decode of the registered state gated by busy rather than a flop.
  assign cmd_valid = (state == S_ISSUE) && !busy;

  // Next-state and next-register values
  always_comb begin
    state_nxt  = state;
    crom_a_nxt = CROM_A;
    cmd_nxt    = cmd;
    issued_nxt = issued_cnt;
    error_nxt  = error;
    tmo_nxt    = tmo_cnt;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          crom_a_nxt = '0;
          issued_nxt = '0;
          error_nxt  = 1'b0;
          state_nxt  = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        cmd_nxt = CROM_Q;
        if (CROM_Q < CODE_ILLEGAL) begin
          tmo_nxt   = '0;
          state_nxt = S_ISSUE;
        end else begin
          error_nxt = 1'b1;
          if (CROM_A == LAST_A) begin
            state_nxt = S_FINISH;
          end else begin
            crom_a_nxt = CROM_A + AW'(1);
            state_nxt  = S_FETCH;
          end
        end
      end
      S_ISSUE: begin
        // An arriving busy=0 wins over a timeout expiring in the same cycle
        if (!busy) begin
          if (issued_cnt != CNT_MAX) issued_nxt = issued_cnt + 7'd1;
          state_nxt = S_HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          error_nxt = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      S_HOLD: begin
        if (cmd == CODE_WRITE) begin
          tmo_nxt   = '0;
          state_nxt = S_WAIT_DONE;
        end else if (CROM_A == LAST_A) begin
          error_nxt = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          crom_a_nxt = CROM_A + AW'(1);
          state_nxt  = S_FETCH;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
          state_nxt = S_FINISH;
        end else if (tmo_cnt == TMO_LAST) begin
          error_nxt = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      CROM_A     <= '0;
      CROM_rd    <= 1'b0;
      cmd        <= '0;
      issued_cnt <= '0;
      error      <= 1'b0;
      finish     <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      CROM_A     <= crom_a_nxt;
      CROM_rd    <= (state_nxt == S_FETCH);
      cmd        <= cmd_nxt;
      issued_cnt <= issued_nxt;
      error      <= error_nxt;
      finish     <= (state_nxt == S_FINISH);
      tmo_cnt    <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host: synchronous ROM model, per-cycle strobe log,
// immediate-assertion checks against hand-derived cycle numbers.
module tb_lcd_cmd_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] crom_q;
  logic       crom_rd;
  logic [5:0] crom_a;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic [6:0] issued_cnt;
  logic       finish;
  logic       error;

  lcd_cmd_host #(.CMD_DEPTH(64), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .CROM_Q     (crom_q),
    .CROM_rd    (crom_rd),
    .CROM_A     (crom_a),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt),
    .finish     (finish),
    .error      (error)
  );

  always #5 clk = ~clk;

  logic [3:0] rom [64];
  always @(posedge clk) if (crom_rd) crom_q <= rom[crom_a];

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc;
  int         pv_cyc[$];
  logic [3:0] pv_cmd[$];
  int         fin_cyc, wr_cyc, busy_lo, busy_hi;
  bit         busy_stuck;
  int         back2back, busy_pulse, hold_bad;
  logic       prev_v;
  logic [3:0] prev_cmd;
  logic       rd1;
  logic [5:0] a1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 64; i++) rom[i] = v;
  endtask

  // Pulse start across edge 0; afterwards the bench sits in cycle 1.
  task automatic start_run();
    pv_cyc.delete();
    pv_cmd.delete();
    fin_cyc = 0; wr_cyc = 0; back2back = 0; busy_pulse = 0; hold_bad = 0;
    prev_v = 1'b0; prev_cmd = '0; rd1 = 1'b0; a1 = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  // Step cycles until finish, a first strobe (if stop_at_cv) or the budget.
  task automatic run(input int max_cyc, input bit stop_at_cv);
    while (cyc <= max_cyc) begin
      busy = busy_stuck || (cyc >= busy_lo && cyc <= busy_hi);
      done = (wr_cyc > 0) && (cyc == wr_cyc + 2);
      @(negedge clk);
      if (prev_v && cmd !== prev_cmd) hold_bad++;
      if (cmd_valid) begin
        pv_cyc.push_back(cyc);
        pv_cmd.push_back(cmd);
        if (busy) busy_pulse++;
        if (prev_v) back2back++;
        if (cmd == 4'd0 && wr_cyc == 0) wr_cyc = cyc;
      end
      prev_v = cmd_valid;
      prev_cmd = cmd;
      if (cyc == 1) begin rd1 = crom_rd; a1 = crom_a; end
      if (finish && fin_cyc == 0) fin_cyc = cyc;
      if (fin_cyc != 0 || (stop_at_cv && cmd_valid)) return;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic int pv_c(input int i);
    return (i < pv_cyc.size()) ? pv_cyc[i] : -1;
  endfunction

  function automatic int pv_k(input int i);
    return (i < pv_cmd.size()) ? int'(pv_cmd[i]) : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0;
    busy_lo = 0; busy_hi = -1; busy_stuck = 1'b0;
    fill(4'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_outputs", {14'd0, crom_rd, crom_a, cmd, issued_cnt, finish, error}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Script {1,4,5,0}, busy low, done two cycles after WRITE
    fill(4'd1);
    rom[0] = 4'd1; rom[1] = 4'd4; rom[2] = 4'd5; rom[3] = 4'd0;
    start_run();
    run(60, 1'b0);
    chk("t1_rd_cycle1", 32'(rd1), 1);
    chk("t1_addr_cycle1", 32'(a1), 0);
    chk("t1_npulses", pv_cyc.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_pulse%0d_cycle", i), pv_c(i), 3 + 4 * i);
    chk("t1_cmd0", pv_k(0), 1);
    chk("t1_cmd1", pv_k(1), 4);
    chk("t1_cmd2", pv_k(2), 5);
    chk("t1_cmd3", pv_k(3), 0);
    chk("t1_finish_cycle", fin_cyc, 18);
    chk("t1_issued", 32'(issued_cnt), 4);
    chk("t1_error", 32'(error), 0);
    chk("t1_addr_final", 32'(crom_a), 3);
    chk("t1_back2back", back2back, 0);
    chk("t1_cmd_hold", hold_bad, 0);

    // Script {5,0}, busy high over cycles 3..10; restart from FINISH
    fill(4'd1);
    rom[0] = 4'd5; rom[1] = 4'd0;
    busy_lo = 3; busy_hi = 10;
    start_run();
    chk("t2_finish_cleared", 32'(finish), 0);
    run(60, 1'b0);
    chk("t2_first_pulse", pv_c(0), 11);
    chk("t2_first_cmd", pv_k(0), 5);
    chk("t2_write_pulse", pv_c(1), 15);
    chk("t2_pulse_while_busy", busy_pulse, 0);
    chk("t2_finish_cycle", fin_cyc, 18);
    chk("t2_issued", 32'(issued_cnt), 2);
    chk("t2_error", 32'(error), 0);
    busy_lo = 0; busy_hi = -1;

    // Script {3,13,0}: illegal code skipped
    fill(4'd1);
    rom[0] = 4'd3; rom[1] = 4'd13; rom[2] = 4'd0;
    start_run();
    run(60, 1'b0);
    chk("t3_npulses", pv_cyc.size(), 2);
    chk("t3_cmd0", pv_k(0), 3);
    chk("t3_write_cmd", pv_k(1), 0);
    chk("t3_write_cycle", pv_c(1), 9);
    chk("t3_finish_cycle", fin_cyc, 12);
    chk("t3_issued", 32'(issued_cnt), 2);
    chk("t3_error", 32'(error), 1);

    // busy stuck high: timeout after 16 ISSUE cycles (3..18)
    fill(4'd1);
    rom[0] = 4'd2; rom[1] = 4'd0;
    busy_stuck = 1'b1;
    start_run();
    chk("t4_error_cleared", 32'(error), 0);
    run(60, 1'b0);
    chk("t4_npulses", pv_cyc.size(), 0);
    chk("t4_finish_cycle", fin_cyc, 19);
    chk("t4_error", 32'(error), 1);
    chk("t4_issued", 32'(issued_cnt), 0);
    busy_stuck = 1'b0;

    // No WRITE anywhere: all 64 entries issued, error after last HOLD
    fill(4'd7);
    start_run();
    run(400, 1'b0);
    chk("t5_npulses", pv_cyc.size(), 64);
    chk("t5_last_pulse", pv_c(63), 255);
    chk("t5_finish_cycle", fin_cyc, 257);
    chk("t5_issued", 32'(issued_cnt), 64);
    chk("t5_error", 32'(error), 1);
    chk("t5_addr_final", 32'(crom_a), 63);
    chk("t5_back2back", back2back, 0);

    // Reset asserted during the first cmd_valid cycle
    fill(4'd1);
    rom[0] = 4'd1; rom[1] = 4'd4; rom[2] = 4'd5; rom[3] = 4'd0;
    start_run();
    run(20, 1'b1);
    chk("t6_strobe_cycle", cyc, 3);
    chk("t6_strobe_high", 32'(cmd_valid), 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_cmd_valid_async", 32'(cmd_valid), 0);
    chk("t6_outputs_async", {14'd0, crom_rd, crom_a, cmd, issued_cnt, finish, error}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    start_run();
    run(60, 1'b0);
    chk("t6_rd_cycle1", 32'(rd1), 1);
    chk("t6_addr_cycle1", 32'(a1), 0);
    chk("t6_first_pulse", pv_c(0), 3);
    chk("t6_first_cmd", pv_k(0), 1);
    chk("t6_finish_cycle", fin_cyc, 18);
    chk("t6_issued", 32'(issued_cnt), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
